// File: rtl/mult_8bit_seq.sv
// ============================================================================
// Module   : mult_8bit_seq (+ full_adder_8bit)
// Brief    : Shift-and-add 8x8->16 unsigned multiplier, one add per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module full_adder_8bit (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] Sum,
    output logic       Cout
);
    logic [8:0] w_carry;

    assign w_carry[0] = Cin;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign Sum[i]         = A[i] ^ B[i] ^ w_carry[i];
        assign w_carry[i + 1] = (A[i] & B[i]) | (w_carry[i] & (A[i] ^ B[i]));
    end

    assign Cout = w_carry[8];
endmodule

module mult_8bit_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_m;
    logic [7:0] r_q;
    logic [7:0] r_acc;
    logic [2:0] r_cnt;
    logic       r_in_ready;
    logic       r_out_valid;
    logic       r_busy;

    logic [7:0] w_s;
    logic       w_c;

    full_adder_8bit u_adder (
        .A    (r_acc),
        .B    (r_m),
        .Cin  (1'b0),
        .Sum  (w_s),
        .Cout (w_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_m         <= 8'h00;
            r_q         <= 8'h00;
            r_acc       <= 8'h00;
            r_cnt       <= 3'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_m        <= a;
                        r_q        <= b;
                        r_acc      <= 8'h00;
                        r_cnt      <= 3'd0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    // Add-or-skip, then shift the whole {ACC,Q} pair right by one.
                    if (r_q[0]) begin
                        {r_acc, r_q} <= {w_c, w_s, r_q[7:1]};
                    end else begin
                        {r_acc, r_q} <= {1'b0, r_acc, r_q[7:1]};
                    end
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign product   = {r_acc, r_q};
endmodule

`default_nettype wire
